// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
// Keeps the state encoding and counter sizing in one place.
package sar_search_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      EVAL,
      FINISH
   } sar_state_t;

   function automatic int iters_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/sar_bounds.sv
// Search window for the binary search: lo/hi registers, midpoint guess and
// the empty-range flag computed from the bounds as they will be after an update.
module sar_bounds #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             upd_gt,
   input  logic             upd_lt,
   input  logic [WIDTH-1:0] guess,
   output logic [WIDTH-1:0] mid,
   output logic             empty
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] TOP = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0]   lo;
   logic [WIDTH:0]   hi;
   logic [WIDTH:0]   lo_n;
   logic [WIDTH:0]   hi_n;
   logic [WIDTH:0]   g;
   logic [WIDTH+1:0] sum;
   logic             g_zero;

   assign g      = {1'b0, guess};
   assign g_zero = (guess == '0);
   assign sum    = {1'b0, lo} + {1'b0, hi};
   assign mid    = sum[WIDTH:1];

   // A "greater" verdict on guess 0 empties the range without touching hi.
   always_comb begin
      lo_n = lo;
      hi_n = hi;
      if (upd_lt) begin
         lo_n = g + ONE;
      end
      if (upd_gt && !g_zero) begin
         hi_n = g - ONE;
      end
   end

   assign empty = (upd_gt && g_zero) || (lo_n > hi_n);

   always_ff @(posedge clk) begin
      if (rst) begin
         lo <= '0;
         hi <= '0;
      end else if (load) begin
         lo <= '0;
         hi <= TOP;
      end else begin
         lo <= lo_n;
         hi <= hi_n;
      end
   end

endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator for a magnitude comparator: issues guesses on cmp_a,
// consumes EQ/GT/LT and reports the matching value or why the search stopped.
module sar_search_ctrl
   import sar_search_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int CMP_LAT = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          found,
   output logic                          err,
   output logic [WIDTH-1:0]              result,
   output logic [iters_width(WIDTH)-1:0] iters,
   output logic [WIDTH-1:0]              cmp_a,
   output logic                          cmp_req,
   input  logic                          cmp_eq,
   input  logic                          cmp_gt,
   input  logic                          cmp_lt
);

   localparam int IW = iters_width(WIDTH);
   localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
   localparam logic [IW-1:0] ITER_CAP  = IW'(WIDTH + 1);
   localparam logic [IW-1:0] ITER_ONE  = IW'(1);
   localparam logic [CW-1:0] WAIT_LAST = CW'((CMP_LAT > 0) ? CMP_LAT - 1 : 0);
   localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

   sar_state_t       state;
   logic [CW-1:0]    wcnt;
   logic [WIDTH-1:0] mid;
   logic             empty;
   logic             accept;
   logic             in_eval;
   logic             onehot;
   logic             upd_gt;
   logic             upd_lt;
   logic             stop;

   assign accept  = (state == IDLE) && start;
   assign in_eval = (state == EVAL);
   assign onehot  = $onehot({cmp_eq, cmp_gt, cmp_lt});
   assign upd_gt  = in_eval && onehot && cmp_gt;
   assign upd_lt  = in_eval && onehot && cmp_lt;
   assign stop    = !onehot || cmp_eq || empty || (iters == ITER_CAP);

   sar_bounds #(
      .WIDTH (WIDTH)
   ) u_bounds (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .upd_gt (upd_gt),
      .upd_lt (upd_lt),
      .guess  (cmp_a),
      .mid    (mid),
      .empty  (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wcnt    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         found   <= 1'b0;
         err     <= 1'b0;
         result  <= '0;
         iters   <= '0;
         cmp_a   <= '0;
         cmp_req <= 1'b0;
      end else begin
         cmp_req <= 1'b0;
         done    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= ISSUE;
                  busy   <= 1'b1;
                  found  <= 1'b0;
                  err    <= 1'b0;
                  result <= '0;
                  iters  <= '0;
               end
            end
            ISSUE: begin
               cmp_a   <= mid;
               cmp_req <= 1'b1;
               iters   <= iters + ITER_ONE;
               wcnt    <= '0;
               state   <= (CMP_LAT > 0) ? WAIT : EVAL;
            end
            WAIT: begin
               if (wcnt == WAIT_LAST) begin
                  state <= EVAL;
               end else begin
                  wcnt <= wcnt + WAIT_ONE;
               end
            end
            EVAL: begin
               // Hitting the iteration cap with no verdict means the comparator lied.
               if (stop) begin
                  state  <= FINISH;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= cmp_a;
                  found  <= onehot && cmp_eq;
                  err    <= !onehot || (!cmp_eq && !empty);
               end else begin
                  state <= ISSUE;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a combinational comparator model (with forced
// flag modes) and a 2-cycle-latency comparator model drive two instances.
module tb_sar_search_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance 0: CMP_LAT=0, combinational comparator with forcing modes
   logic       start0, busy0, done0, found0, err0, req0;
   logic       eq0, gt0, lt0;
   logic [3:0] result0, cmp_a0, target0;
   logic [2:0] iters0;
   int         mode0;

   always_comb begin
      eq0 = (cmp_a0 == target0);
      gt0 = (cmp_a0 > target0);
      lt0 = (cmp_a0 < target0);
      if (mode0 == 1) begin
         eq0 = 1'b0;
         gt0 = 1'b1;
         lt0 = 1'b0;
      end else if (mode0 == 2) begin
         eq0 = 1'b1;
         gt0 = 1'b1;
         lt0 = 1'b0;
      end
   end

   sar_search_ctrl #(.WIDTH(4), .CMP_LAT(0)) u0 (
      .clk     (clk),
      .rst     (rst),
      .start   (start0),
      .busy    (busy0),
      .done    (done0),
      .found   (found0),
      .err     (err0),
      .result  (result0),
      .iters   (iters0),
      .cmp_a   (cmp_a0),
      .cmp_req (req0),
      .cmp_eq  (eq0),
      .cmp_gt  (gt0),
      .cmp_lt  (lt0)
   );

   // instance 1: CMP_LAT=2, comparator sees cmp_a two cycles late
   logic       start1, busy1, done1, found1, err1, req1;
   logic       eq1, gt1, lt1;
   logic [3:0] result1, cmp_a1, target1;
   logic [2:0] iters1;
   logic [3:0] a_d1 = 4'd0;
   logic [3:0] a_d2 = 4'd0;

   always @(posedge clk) begin
      a_d1 <= cmp_a1;
      a_d2 <= a_d1;
   end
   assign eq1 = (a_d2 == target1);
   assign gt1 = (a_d2 > target1);
   assign lt1 = (a_d2 < target1);

   sar_search_ctrl #(.WIDTH(4), .CMP_LAT(2)) u1 (
      .clk     (clk),
      .rst     (rst),
      .start   (start1),
      .busy    (busy1),
      .done    (done1),
      .found   (found1),
      .err     (err1),
      .result  (result1),
      .iters   (iters1),
      .cmp_a   (cmp_a1),
      .cmp_req (req1),
      .cmp_eq  (eq1),
      .cmp_gt  (gt1),
      .cmp_lt  (lt1)
   );

   // reference model: plain binary search over 0..15
   int exp_q[$];
   bit exp_found;
   bit exp_err;

   function automatic void model(input int tgt, input int mode);
      int lo;
      int hi;
      int g;
      bit fin;
      exp_q.delete();
      exp_found = 0;
      exp_err   = 0;
      lo  = 0;
      hi  = 15;
      fin = 0;
      while (!fin) begin
         g = (lo + hi) / 2;
         exp_q.push_back(g);
         if (mode == 2) begin
            exp_err = 1;
            fin     = 1;
         end else if (mode == 0 && g == tgt) begin
            exp_found = 1;
            fin       = 1;
         end else if (mode == 1 || g > tgt) begin
            if (g == 0) fin = 1;
            else begin
               hi = g - 1;
               if (lo > hi) fin = 1;
            end
         end else begin
            lo = g + 1;
            if (lo > hi) fin = 1;
         end
         if (!fin && exp_q.size() == 5) begin
            exp_err = 1;
            fin     = 1;
         end
      end
   endfunction

   // captured observations from a search on instance 0
   int         obs_q[$];
   bit         got_timeout;
   logic       got_busy_first;
   logic       got_found;
   logic       got_err;
   logic [3:0] got_result;
   logic [2:0] got_iters;
   int         overlap;

   task automatic run0(input logic [3:0] tgt, input int mode);
      target0 = tgt;
      mode0   = mode;
      obs_q.delete();
      got_timeout = 1;
      overlap     = 0;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      got_busy_first = busy0;
      for (int n = 0; n < 60; n++) begin
         if (req0) obs_q.push_back(int'(cmp_a0));
         if (busy0 && done0) overlap++;
         if (done0) begin
            got_found   = found0;
            got_err     = err0;
            got_result  = result0;
            got_iters   = iters0;
            got_timeout = 0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      start0 = 1'b0;
      start1 = 1'b0;
      target0 = 4'd0;
      target1 = 4'd0;
      mode0 = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy0, done0, found0, err0} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags0 got=%b exp=0000", {busy0, done0, found0, err0});
      end
      checks++;
      if ({result0, iters0, cmp_a0, req0} !== 12'b0) begin
         failures++;
         $display("FAIL reset_data0 got=%h exp=000", {result0, iters0, cmp_a0, req0});
      end
      checks++;
      if ({busy1, done1, found1, err1, result1, iters1, cmp_a1, req1} !== 16'b0) begin
         failures++;
         $display("FAIL reset_all1 got=%h exp=0000",
                  {busy1, done1, found1, err1, result1, iters1, cmp_a1, req1});
      end
   endtask

   localparam int DT  [5]    = '{5, 0, 15, 0, 0};
   localparam int DM  [5]    = '{0, 0, 0, 1, 2};
   localparam int DN  [5]    = '{3, 4, 5, 4, 1};
   localparam int DG  [5][5] = '{'{7, 3, 5, 0, 0},
                                 '{7, 3, 1, 0, 0},
                                 '{7, 11, 13, 14, 15},
                                 '{7, 3, 1, 0, 0},
                                 '{7, 0, 0, 0, 0}};
   localparam int DF  [5]    = '{1, 1, 1, 0, 0};
   localparam int DE  [5]    = '{0, 0, 0, 0, 1};
   localparam int DR  [5]    = '{5, 0, 15, 0, 7};

   task automatic test_directed();
      bit ok;
      for (int i = 0; i < 5; i++) begin
         run0(4'(DT[i]), DM[i]);
         checks++;
         if (got_timeout !== 1'b0) begin
            failures++;
            $display("FAIL dir%0d_timeout got=no_done exp=done", i);
            continue;
         end
         checks++;
         if (got_busy_first !== 1'b1) begin
            failures++;
            $display("FAIL dir%0d_busy_after_accept got=%b exp=1", i, got_busy_first);
         end
         checks++;
         if (overlap !== 0) begin
            failures++;
            $display("FAIL dir%0d_busy_done_overlap got=%0d exp=0", i, overlap);
         end
         ok = (obs_q.size() == DN[i]);
         for (int k = 0; k < obs_q.size() && ok; k++)
            if (obs_q[k] != DG[i][k]) ok = 0;
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL dir%0d_guesses got=%p exp_count=%0d", i, obs_q, DN[i]);
         end
         checks++;
         if ({got_found, got_err} !== {1'(DF[i]), 1'(DE[i])}) begin
            failures++;
            $display("FAIL dir%0d_found_err got=%b%b exp=%0d%0d",
                     i, got_found, got_err, DF[i], DE[i]);
         end
         checks++;
         if (got_result !== 4'(DR[i])) begin
            failures++;
            $display("FAIL dir%0d_result got=%0d exp=%0d", i, got_result, DR[i]);
         end
         checks++;
         if (got_iters !== 3'(DN[i])) begin
            failures++;
            $display("FAIL dir%0d_iters got=%0d exp=%0d", i, got_iters, DN[i]);
         end
      end
   endtask

   task automatic test_random();
      int  tgt;
      int  mode;
      bit  ok;
      for (int i = 0; i < 24; i++) begin
         tgt  = int'($urandom_range(0, 15));
         mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
         model(tgt, mode);
         run0(4'(tgt), mode);
         checks++;
         if (got_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rnd%0d_timeout got=no_done exp=done", i);
            continue;
         end
         ok = (obs_q.size() == exp_q.size());
         for (int k = 0; k < obs_q.size() && ok; k++)
            if (obs_q[k] != exp_q[k]) ok = 0;
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL rnd%0d_guesses tgt=%0d got=%p exp=%p", i, tgt, obs_q, exp_q);
         end
         checks++;
         if ({got_found, got_err} !== {exp_found, exp_err}) begin
            failures++;
            $display("FAIL rnd%0d_found_err got=%b%b exp=%b%b",
                     i, got_found, got_err, exp_found, exp_err);
         end
         checks++;
         if (got_result !== 4'(exp_q[$])) begin
            failures++;
            $display("FAIL rnd%0d_result got=%0d exp=%0d", i, got_result, exp_q[$]);
         end
         checks++;
         if (got_iters !== 3'(exp_q.size())) begin
            failures++;
            $display("FAIL rnd%0d_iters got=%0d exp=%0d", i, got_iters, exp_q.size());
         end
      end
   endtask

   task automatic test_back_to_back();
      int  gap;
      bit  seen;
      target0 = 4'd5;
      mode0   = 0;
      @(negedge clk) start0 = 1'b1;
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (done0) seen = 1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL b2b_first_done got=no_done exp=done");
      end
      gap  = 0;
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         gap++;
         if (req0) seen = 1;
      end
      checks++;
      if (!seen || gap != 3) begin
         failures++;
         $display("FAIL b2b_restart_gap got=%0d exp=3", gap);
      end
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (done0) seen = 1;
      end
      start0 = 1'b0;
      checks++;
      if (!seen || {found0, err0, result0, iters0} !== {2'b10, 4'd5, 3'd3}) begin
         failures++;
         $display("FAIL b2b_second_search got=f%b e%b r%0d i%0d exp=f1 e0 r5 i3",
                  found0, err0, result0, iters0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle_after_release got=%b exp=0", busy0);
      end
   endtask

   task automatic test_latency_and_reset();
      int  rc[$];
      int  ga[$];
      bit  seen;
      int  dpulse;
      target1 = 4'd9;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      seen = 0;
      for (int n = 0; n < 80 && !seen; n++) begin
         if (req1) begin
            rc.push_back(cyc);
            ga.push_back(int'(cmp_a1));
         end
         if (done1) seen = 1;
         else @(negedge clk);
      end
      checks++;
      if (!seen || ga.size() != 3 || ga[0] != 7 || ga[1] != 11 || ga[2] != 9) begin
         failures++;
         $display("FAIL lat_guesses got=%p exp=7,11,9", ga);
      end
      checks++;
      if (rc.size() != 3 || rc[1] - rc[0] != 4 || rc[2] - rc[1] != 4) begin
         failures++;
         $display("FAIL lat_req_spacing got=%p exp=step4", rc);
      end
      checks++;
      if ({found1, err1, result1, iters1} !== {2'b10, 4'd9, 3'd3}) begin
         failures++;
         $display("FAIL lat_outcome got=f%b e%b r%0d i%0d exp=f1 e0 r9 i3",
                  found1, err1, result1, iters1);
      end
      target1 = 4'(12);
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy1 !== 1'b1 || iters1 == 3'd0) begin
         failures++;
         $display("FAIL rst_pre_busy got=b%b i%0d exp=b1 i>0", busy1, iters1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy1, done1, found1, err1, result1, iters1, cmp_a1, req1} !== 16'b0) begin
         failures++;
         $display("FAIL rst_mid_search got=%h exp=0000",
                  {busy1, done1, found1, err1, result1, iters1, cmp_a1, req1});
      end
      checks++;
      if ({found0, result0, iters0} !== 8'b0) begin
         failures++;
         $display("FAIL rst_held_outputs0 got=%h exp=00", {found0, result0, iters0});
      end
      dpulse = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done1 || busy1) dpulse++;
      end
      checks++;
      if (dpulse !== 0) begin
         failures++;
         $display("FAIL rst_no_done_after got=%0d exp=0", dpulse);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_latency_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
